// File: rtl/interrupt_sequencer.sv
// 8259-style interrupt sequencer: priority resolve, INT/INTA handshake, ISR.
// Optional AUTO_EOI_EN: clear the served ISR bit on the second INTA rise.
module interrupt_sequencer #(
    parameter int NUM_IRQ    = 8,
    parameter int VEC_BASE_W = 5,
    localparam int IDX_W     = $clog2(NUM_IRQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IRQ-1:0]       irr,
    input  logic [NUM_IRQ-1:0]       imr,
    input  logic                     inta_n,
    input  logic                     eoi,
    input  logic                     eoi_specific,
    input  logic [IDX_W-1:0]         eoi_level,
    input  logic [VEC_BASE_W-1:0]    vector_base,
    output logic                     int_out,
    output logic [NUM_IRQ-1:0]       clear_irr,
    output logic [NUM_IRQ-1:0]       isr,
    output logic [VEC_BASE_W+IDX_W-1:0] data_out,
    output logic                     data_oe
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK1,
        GAP,
        ACK2
    } state_t;

    state_t             state;
    logic               inta_q;
    logic [IDX_W-1:0]   idx;
`ifdef AUTO_EOI_EN
    logic               spur;
`endif

    logic [NUM_IRQ-1:0] pend;
    logic               cand_vld;
    logic [IDX_W-1:0]   cand_idx;
    logic               isr_vld;
    logic [IDX_W-1:0]   isr_low;
    logic               eligible;
    logic               fall;
    logic               rise;
    logic [NUM_IRQ-1:0] eoi_mask;
    logic [NUM_IRQ-1:0] set_mask;
    logic [NUM_IRQ-1:0] isr_next;

    // Fixed priority: lowest index wins, for requests and for in-service levels.
    always_comb begin
        pend     = irr & ~imr;
        cand_vld = 1'b0;
        cand_idx = '0;
        isr_vld  = 1'b0;
        isr_low  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_W'(i);
            end
            if (isr[i]) begin
                isr_vld = 1'b1;
                isr_low = IDX_W'(i);
            end
        end
        eligible = cand_vld && (!isr_vld || (cand_idx < isr_low));
    end

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

    // Clears are applied before the set so a same-cycle set survives.
    always_comb begin
        eoi_mask = '0;
        set_mask = '0;
        if (eoi) begin
            if (eoi_specific)
                eoi_mask[eoi_level] = 1'b1;
            else if (isr_vld)
                eoi_mask[isr_low] = 1'b1;
        end
`ifdef AUTO_EOI_EN
        if ((state == ACK2) && rise && !spur)
            eoi_mask[idx] = 1'b1;
`endif
        if ((state == REQ) && fall && eligible)
            set_mask[cand_idx] = 1'b1;
        isr_next = (isr & ~eoi_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_q    <= 1'b1;
            idx       <= '0;
            int_out   <= 1'b0;
            clear_irr <= '0;
            isr       <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
`ifdef AUTO_EOI_EN
            spur      <= 1'b0;
`endif
        end else begin
            inta_q    <= inta_n;
            isr       <= isr_next;
            clear_irr <= '0;
            unique case (state)
                IDLE: begin
                    if (eligible) begin
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                REQ: begin
                    if (fall) begin
                        state     <= ACK1;
                        clear_irr <= set_mask;
                        idx       <= eligible ? cand_idx : '1;
`ifdef AUTO_EOI_EN
                        spur      <= !eligible;
`endif
                    end
                end
                ACK1: begin
                    if (rise)
                        state <= GAP;
                end
                GAP: begin
                    if (fall) begin
                        state    <= ACK2;
                        int_out  <= 1'b0;
                        data_out <= {vector_base, idx};
                        data_oe  <= 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        state    <= IDLE;
                        data_out <= '0;
                        data_oe  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer.
// Expected values are hand-derived from the handshake timing.
module tb_interrupt_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta_n;
    logic       eoi;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic [4:0] vector_base;
    logic       int_out;
    logic [7:0] clear_irr;
    logic [7:0] isr;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;

`ifdef AUTO_EOI_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    interrupt_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irr          (irr),
        .imr          (imr),
        .inta_n       (inta_n),
        .eoi          (eoi),
        .eoi_specific (eoi_specific),
        .eoi_level    (eoi_level),
        .vector_base  (vector_base),
        .int_out      (int_out),
        .clear_irr    (clear_irr),
        .isr          (isr),
        .data_out     (data_out),
        .data_oe      (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        irr          = 8'h00;
        imr          = 8'h00;
        inta_n       = 1'b1;
        eoi          = 1'b0;
        eoi_specific = 1'b0;
        eoi_level    = 3'd0;
        vector_base  = 5'h08;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Two full INTA pulses, starting in REQ.
    task automatic serve();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({int_out, clear_irr, isr, data_out, data_oe} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0",
                     {int_out, clear_irr, isr, data_out, data_oe});
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        irr = 8'h04;
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL basic_int got %b exp 1", int_out);
        end
        inta_n = 1'b0; tick();
        checks++;
        if (clear_irr !== 8'h04 || isr !== 8'h04) begin
            errors++;
            $display("FAIL basic_ack1 got clr=%h isr=%h exp 04/04", clear_irr, isr);
        end
        irr = 8'h00;
        tick();
        checks++;
        if (clear_irr !== 8'h00 || data_oe !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got clr=%h oe=%b exp 00/0", clear_irr, data_oe);
        end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h42 || data_oe !== 1'b1 || int_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_vec got d=%h oe=%b int=%b exp 42/1/0",
                     data_out, data_oe, int_out);
        end
        tick();
        checks++;
        if (data_out !== 8'h42 || data_oe !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold got d=%h oe=%b exp 42/1", data_out, data_oe);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (data_out !== 8'h00 || data_oe !== 1'b0 ||
            isr !== (AUTO ? 8'h00 : 8'h04)) begin
            errors++;
            $display("FAIL basic_end got d=%h oe=%b isr=%h", data_out, data_oe, isr);
        end
    endtask

    task automatic test_mask();
        do_reset();
        irr = 8'h04;
        imr = 8'h04;
        tick();
        tick();
        checks++;
        if (int_out !== 1'b0) begin
            errors++;
            $display("FAIL mask_int got %b exp 0", int_out);
        end
        imr = 8'h00;
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL unmask_int got %b exp 1", int_out);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        irr = 8'h08;
        tick();
        irr = 8'h0A;
        tick();
        inta_n = 1'b0; tick();
        checks++;
        if (clear_irr !== 8'h02 || isr !== 8'h02) begin
            errors++;
            $display("FAIL preempt_ack got clr=%h isr=%h exp 02/02", clear_irr, isr);
        end
        irr = 8'h08;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h41) begin
            errors++;
            $display("FAIL preempt_vec got %h exp 41", data_out);
        end
        inta_n = 1'b1; tick();
    endtask

    task automatic test_nested();
        do_reset();
        irr = 8'h04;
        tick();
        serve();
        irr = 8'h11;
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL nest_int got %b exp 1", int_out);
        end
        inta_n = 1'b0; tick();
        checks++;
        if (isr !== 8'h05 || clear_irr !== 8'h01) begin
            errors++;
            $display("FAIL nest_ack got isr=%h clr=%h exp 05/01", isr, clear_irr);
        end
        irr = 8'h10;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h40) begin
            errors++;
            $display("FAIL nest_vec got %h exp 40", data_out);
        end
        inta_n = 1'b1; tick();
        tick();
        tick();
        checks++;
        if (int_out !== 1'b0 || isr !== 8'h05) begin
            errors++;
            $display("FAIL nest_block got int=%b isr=%h exp 0/05", int_out, isr);
        end
        eoi = 1'b1; tick();
        eoi = 1'b0; tick();
        checks++;
        if (int_out !== 1'b0 || isr !== 8'h04) begin
            errors++;
            $display("FAIL nest_eoi1 got int=%b isr=%h exp 0/04", int_out, isr);
        end
        eoi = 1'b1; tick();
        eoi = 1'b0;
        checks++;
        if (int_out !== 1'b0 || isr !== 8'h00) begin
            errors++;
            $display("FAIL nest_eoi2 got int=%b isr=%h exp 0/00", int_out, isr);
        end
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL nest_resume got %b exp 1", int_out);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        irr = 8'h80;
        tick();
        irr = 8'h00;
        tick();
        checks++;
        if (int_out !== 1'b1) begin
            errors++;
            $display("FAIL spur_hold got %b exp 1", int_out);
        end
        inta_n = 1'b0; tick();
        checks++;
        if (clear_irr !== 8'h00 || isr !== 8'h00) begin
            errors++;
            $display("FAIL spur_ack got clr=%h isr=%h exp 00/00", clear_irr, isr);
        end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (data_out !== 8'h47 || data_oe !== 1'b1) begin
            errors++;
            $display("FAIL spur_vec got d=%h oe=%b exp 47/1", data_out, data_oe);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (data_out !== 8'h00 || data_oe !== 1'b0 || isr !== 8'h00) begin
            errors++;
            $display("FAIL spur_end got d=%h oe=%b isr=%h", data_out, data_oe, isr);
        end
    endtask

    task automatic test_specific_eoi();
        do_reset();
        irr = 8'h08;
        tick();
        serve();
        irr = 8'h02;
        tick();
        serve();
        irr = 8'h00;
        tick();
        checks++;
        if (isr !== 8'h0A) begin
            errors++;
            $display("FAIL seoi_setup got %h exp 0A", isr);
        end
        eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
        tick();
        eoi = 1'b0;
        checks++;
        if (isr !== 8'h02) begin
            errors++;
            $display("FAIL seoi_l3 got %h exp 02", isr);
        end
        eoi = 1'b1; eoi_level = 3'd5;
        tick();
        eoi = 1'b0; eoi_specific = 1'b0;
        checks++;
        if (isr !== 8'h02) begin
            errors++;
            $display("FAIL seoi_l5 got %h exp 02", isr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        irr = 8'h04;
        tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({int_out, clear_irr, isr, data_out, data_oe} !== 26'd0) begin
            errors++;
            $display("FAIL areset_outs got %h exp 0",
                     {int_out, clear_irr, isr, data_out, data_oe});
        end
        irr = 8'h00;
        inta_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        tick();
        checks++;
        if (int_out !== 1'b0 || data_oe !== 1'b0 || isr !== 8'h00) begin
            errors++;
            $display("FAIL areset_idle got int=%b oe=%b isr=%h", int_out, data_oe, isr);
        end
        inta_n = 1'b1;
        tick();
    endtask

    task automatic test_auto_eoi();
        do_reset();
        irr = 8'h01;
        tick();
        inta_n = 1'b0; tick();
        checks++;
        if (isr !== 8'h01 || clear_irr !== 8'h01) begin
            errors++;
            $display("FAIL auto_ack got isr=%h clr=%h exp 01/01", isr, clear_irr);
        end
        irr = 8'h00;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        checks++;
        if (isr !== 8'h01 || data_out !== 8'h40) begin
            errors++;
            $display("FAIL auto_mid got isr=%h d=%h exp 01/40", isr, data_out);
        end
        inta_n = 1'b1; tick();
        checks++;
        if (isr !== (AUTO ? 8'h00 : 8'h01)) begin
            errors++;
            $display("FAIL auto_end got isr=%h exp %h", isr, AUTO ? 8'h00 : 8'h01);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_preempt();
        test_spurious();
        test_async_reset();
        test_auto_eoi();
`ifndef AUTO_EOI_EN
        test_nested();
        test_specific_eoi();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
